// File: rtl/alu_cmd_sequencer.sv
// Command sequencer and result FIFO in front of the 2-bit ALU.
// Optional build macro ALU_SEQ_ERRCHK_EN: illegal opcodes 6/7 are blocked and flagged in the FIFO.
//
// state   | meaning
// IDLE    | waiting for a command; ALU inputs hold their last values
// SETTLE  | ALU inputs stable, counting down the settle interval
// CAPTURE | push ALU result and opcode into the result FIFO
module alu_cmd_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned DEPTH         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [1:0] cmd_a,
  input  logic [1:0] cmd_b,
  output logic [1:0] A,
  output logic [1:0] B,
  output logic [2:0] select,
  input  logic [3:0] ALU_Out,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic [2:0] res_op,
  output logic       res_err,
  output logic       busy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [3:0]    SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
`ifdef ALU_SEQ_ERRCHK_EN
  localparam int unsigned EW = 8;
`else
  localparam int unsigned EW = 7;
`endif

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    settle_q, settle_d;
  logic [1:0]    a_q, a_d, b_q, b_d;
  logic [2:0]    sel_q, sel_d;
  logic [2:0]    op_q, op_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          accept, push, pop;
  logic [EW-1:0] push_entry, head_entry;
  logic [EW-1:0] mem_q [DEPTH];
`ifdef ALU_SEQ_ERRCHK_EN
  logic          err_q, err_d;
  logic          bad_op;
`endif

  assign cmd_ready = (state_q == IDLE) && (count_q < DEPTH_C);
  assign accept    = cmd_valid && cmd_ready;
  assign pop       = res_ready && (count_q != '0);
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    op_d     = op_q;
    push     = 1'b0;
`ifdef ALU_SEQ_ERRCHK_EN
    err_d    = err_q;
    bad_op   = cmd_op[2] & cmd_op[1];
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d     = cmd_op;
          settle_d = SETTLE_LOAD;
          state_d  = SETTLE;
`ifdef ALU_SEQ_ERRCHK_EN
          err_d = bad_op;
          if (!bad_op) begin
            a_d   = cmd_a;
            b_d   = cmd_b;
            sel_d = cmd_op;
          end
`else
          a_d   = cmd_a;
          b_d   = cmd_b;
          sel_d = cmd_op;
`endif
        end
      end
      SETTLE: begin
        if (settle_q == 4'd0) state_d = CAPTURE;
        else                  settle_d = settle_q - 4'd1;
      end
      CAPTURE: begin
        push    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ALU_SEQ_ERRCHK_EN
  assign push_entry = err_q ? {4'h0, op_q, 1'b1} : {ALU_Out, op_q, 1'b0};
`else
  assign push_entry = {ALU_Out, op_q};
`endif

  // Space was reserved at acceptance, so push never needs a full check.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      settle_q <= 4'd0;
      a_q      <= 2'd0;
      b_q      <= 2'd0;
      sel_q    <= 3'd0;
      op_q     <= 3'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
`ifdef ALU_SEQ_ERRCHK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      op_q     <= op_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
`ifdef ALU_SEQ_ERRCHK_EN
      err_q    <= err_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign A      = a_q;
  assign B      = b_q;
  assign select = sel_q;

  // Head outputs are forced to zero while empty so stale storage never shows.
  assign res_valid  = (count_q != '0);
  assign head_entry = res_valid ? mem_q[rd_ptr_q] : '0;
`ifdef ALU_SEQ_ERRCHK_EN
  assign res_data = head_entry[7:4];
  assign res_op   = head_entry[3:1];
  assign res_err  = head_entry[0];
`else
  assign res_data = head_entry[6:3];
  assign res_op   = head_entry[2:0];
  assign res_err  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed testbench for alu_cmd_sequencer with a behavioural ALU attached.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_a, cmd_b;
  logic [1:0] A, B;
  logic [2:0] select;
  logic [3:0] alu_out;
  logic       res_valid, res_ready;
  logic [3:0] res_data;
  logic [2:0] res_op;
  logic       res_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_cmd_sequencer #(.SETTLE_CYCLES(1), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .A(A), .B(B), .select(select), .ALU_Out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op), .res_err(res_err),
    .busy(busy)
  );

  function automatic logic [3:0] alu_ref(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b);
    logic [3:0] xa, xb;
    xa = {2'b00, a};
    xb = {2'b00, b};
    case (op)
      3'd0: return xa & xb;
      3'd1: return xa | xb;
      3'd2: return xa ^ xb;
      3'd3: return xa + xb;
      3'd4: return xa - xb;
      3'd5: return xa * xb;
      default: return 4'hF;
    endcase
  endfunction

  always_comb alu_out = alu_ref(select, A, B);

  // Expected FIFO entry {data, op, err} for a command.
  function automatic logic [7:0] exp_entry(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b);
`ifdef ALU_SEQ_ERRCHK_EN
    if (op >= 3'd6) return {4'h0, op, 1'b1};
`endif
    return {alu_ref(op, a, b), op, 1'b0};
  endfunction

  task automatic send_cmd(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b, output int acc_cyc);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: cmd_ready=%b required 1 within 50 cycles", cmd_ready);
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b required 0 within 50 cycles", busy);
    end
  endtask

  task automatic pop_entry(input logic [7:0] e, input string name);
    checks++;
    if ({res_valid, res_data, res_op, res_err} !== {1'b1, e}) begin
      errors++;
      $display("FAIL %s: valid/data/op/err=%b/%h/%0d/%b required 1/%h/%0d/%b",
               name, res_valid, res_data, res_op, res_err, e[7:4], e[3:1], e[0]);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_op = 3'd0; cmd_a = 2'd0; cmd_b = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({A, B, select, res_valid, busy, res_data, res_op, res_err} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs: A/B/sel/rv/busy/data/op/err=%0d/%0d/%0d/%b/%b/%h/%0d/%b required all 0",
               A, B, select, res_valid, busy, res_data, res_op, res_err);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({cmd_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release: cmd_ready/busy=%b/%b required 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_single_op();
    int t;
    res_ready = 1'b0;
    send_cmd(3'd5, 2'd3, 2'd3, t);
    checks++;
    if ({select, A, B, busy, cmd_ready, res_valid} !== {3'd5, 2'd3, 2'd3, 3'b100}) begin
      errors++;
      $display("FAIL single_issue: sel/A/B/busy/rdy/rv=%0d/%0d/%0d/%b/%b/%b required 5/3/3/1/0/0",
               select, A, B, busy, cmd_ready, res_valid);
    end
    @(posedge clk); #1;
    checks++;
    if ({res_valid, busy} !== 2'b01) begin
      errors++;
      $display("FAIL single_n1: res_valid/busy=%b/%b required 0/1", res_valid, busy);
    end
    @(posedge clk); #1;
    checks++;
    if ({res_valid, res_data, res_op, res_err, busy, cmd_ready} !== {1'b1, 4'd9, 3'd5, 1'b0, 2'b01}) begin
      errors++;
      $display("FAIL single_result: rv/data/op/err/busy/rdy=%b/%0d/%0d/%b/%b/%b required 1/9/5/0/0/1",
               res_valid, res_data, res_op, res_err, busy, cmd_ready);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    checks++;
    if ({res_valid, select, A, B} !== {1'b0, 3'd5, 2'd3, 2'd3}) begin
      errors++;
      $display("FAIL single_pop_hold: rv/sel/A/B=%b/%0d/%0d/%0d required 0/5/3/3", res_valid, select, A, B);
    end
  endtask

  task automatic test_back_to_back();
    int t0, t1, t2;
    logic [6:0] got [$];
    logic [6:0] want [3];
    want[0] = {4'd2, 3'd0};
    want[1] = {4'd2, 3'd2};
    want[2] = {4'd2, 3'd3};
    res_ready = 1'b1;
    fork
      begin
        send_cmd(3'd0, 2'd3, 2'd2, t0);
        send_cmd(3'd2, 2'd1, 2'd3, t1);
        send_cmd(3'd3, 2'd1, 2'd1, t2);
      end
      begin
        repeat (20) begin
          @(negedge clk);
          if (res_valid && res_ready) got.push_back({res_data, res_op});
        end
      end
    join
    res_ready = 1'b0;
    checks++;
    if ((t1 - t0) != 3 || (t2 - t1) != 3) begin
      errors++;
      $display("FAIL b2b_rate: accept spacing=%0d,%0d required 3,3", t1 - t0, t2 - t1);
    end
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: results=%0d required 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== want[i]) begin
          errors++;
          $display("FAIL b2b_result%0d: data/op=%0d/%0d required %0d/%0d",
                   i, got[i][6:3], got[i][2:0], want[i][6:3], want[i][2:0]);
        end
      end
    end
  endtask

  task automatic test_full_fifo();
    int t;
    logic [2:0] ops [4];
    logic [1:0] as  [4];
    logic [1:0] bs  [4];
    ops[0] = 3'd3; as[0] = 2'd3; bs[0] = 2'd3;
    ops[1] = 3'd1; as[1] = 2'd2; bs[1] = 2'd1;
    ops[2] = 3'd4; as[2] = 2'd1; bs[2] = 2'd2;
    ops[3] = 3'd0; as[3] = 2'd3; bs[3] = 2'd1;
    res_ready = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      send_cmd(ops[i], as[i], bs[i], t);
      exp_q.push_back(exp_entry(ops[i], as[i], bs[i]));
    end
    wait_idle();
    checks++;
    if ({cmd_ready, res_valid} !== 2'b01) begin
      errors++;
      $display("FAIL full_ready: cmd_ready/res_valid=%b/%b required 0/1", cmd_ready, res_valid);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_hold: cmd_ready=%b required 0", cmd_ready);
    end
    pop_entry(exp_q.pop_front(), "full_pop");
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_release: cmd_ready=%b required 1", cmd_ready);
    end
    for (int i = 0; i < 10; i++) begin
      send_cmd(3'(i % 6), 2'(i % 4), 2'(3 - (i % 4)), t);
      exp_q.push_back(exp_entry(3'(i % 6), 2'(i % 4), 2'(3 - (i % 4))));
      wait_idle();
      pop_entry(exp_q.pop_front(), $sformatf("wrap%0d", i));
    end
    while (exp_q.size() > 0) pop_entry(exp_q.pop_front(), "wrap_drain");
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_empty: res_valid=%b required 0", res_valid);
    end
  endtask

  task automatic test_push_pop();
    int t;
    res_ready = 1'b0;
    send_cmd(3'd1, 2'd2, 2'd1, t);
    send_cmd(3'd2, 2'd3, 2'd1, t);
    wait_idle();
    send_cmd(3'd5, 2'd2, 2'd2, t);
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    checks++;
    if ({busy, res_valid, res_data, res_op} !== {2'b01, 4'd2, 3'd2}) begin
      errors++;
      $display("FAIL pushpop_head: busy/rv/data/op=%b/%b/%0d/%0d required 0/1/2/2",
               busy, res_valid, res_data, res_op);
    end
    pop_entry({4'd2, 3'd2, 1'b0}, "pushpop_e1");
    pop_entry({4'd4, 3'd5, 1'b0}, "pushpop_e2");
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL pushpop_count: res_valid=%b required 0 after two pops", res_valid);
    end
  endtask

  task automatic test_errchk();
    int t;
    res_ready = 1'b0;
    send_cmd(3'd5, 2'd2, 2'd3, t);
    wait_idle();
    send_cmd(3'd7, 2'd1, 2'd1, t);
    checks++;
`ifdef ALU_SEQ_ERRCHK_EN
    if ({select, A, B} !== {3'd5, 2'd2, 2'd3}) begin
      errors++;
      $display("FAIL errchk_hold: sel/A/B=%0d/%0d/%0d required 5/2/3", select, A, B);
    end
`else
    if ({select, A, B} !== {3'd7, 2'd1, 2'd1}) begin
      errors++;
      $display("FAIL errchk_issue: sel/A/B=%0d/%0d/%0d required 7/1/1", select, A, B);
    end
`endif
    wait_idle();
    pop_entry({4'd6, 3'd5, 1'b0}, "errchk_mul");
    pop_entry(exp_entry(3'd7, 2'd1, 2'd1), "errchk_op7");
  endtask

  task automatic test_reset_mid();
    int t;
    res_ready = 1'b0;
    send_cmd(3'd3, 2'd1, 2'd2, t);
    send_cmd(3'd1, 2'd1, 2'd2, t);
    send_cmd(3'd5, 2'd3, 2'd2, t);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({res_valid, busy, A, B, select} !== 9'd0) begin
      errors++;
      $display("FAIL reset_mid: rv/busy/A/B/sel=%b/%b/%0d/%0d/%0d required all 0",
               res_valid, busy, A, B, select);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({cmd_ready, res_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL reset_mid_release: rdy/rv/busy=%b/%b/%b required 1/0/0", cmd_ready, res_valid, busy);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_op();
    test_back_to_back();
    test_full_fifo();
    test_push_pop();
    test_errchk();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Sequential front end for the 2-bit combinational ALU. Accepts operation commands over a valid/ready interface, drives the ALU operand and select inputs from registers, waits a fixed settle interval, captures the 4-bit ALU result, and queues it with its opcode in a small result FIFO that a consumer drains over a second valid/ready interface. It sits between the board-level command source (switch/UART decoder) and the ALU, and it is the only block that drives the ALU's inputs.

## Interface
- SETTLE_CYCLES, 1: cycles the ALU inputs are held before the result is captured; legal range 1–15.
- DEPTH, 4: result FIFO entries; must be a power of two, 2–16.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_op  in  3  select code: 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 5 MUL; 6–7 illegal.
- cmd_a  in  2  operand A.
- cmd_b  in  2  operand B.
- A  out  2  registered operand A to the ALU.
- B  out  2  registered operand B to the ALU.
- select  out  3  registered select to the ALU.
- ALU_Out  in  4  ALU result.
- res_valid  out  1  FIFO head valid.
- res_ready  in  1  consumer pops the head when high together with res_valid.
- res_data  out  4  result at the FIFO head.
- res_op  out  3  opcode at the FIFO head.
- res_err  out  1  error flag at the FIFO head.
- busy  out  1  high in any state other than IDLE.

## Operation
- Three states: IDLE, SETTLE, CAPTURE.
- IDLE: cmd_ready = (state==IDLE) && (fifo_count < DEPTH), combinational. On handshake, load A/B/select from cmd_a/cmd_b/cmd_op, latch the opcode, load settle_cnt = SETTLE_CYCLES-1, then go to SETTLE.
- SETTLE: decrement settle_cnt each cycle. When settle_cnt==0, go to CAPTURE.
- CAPTURE: push {ALU_Out, op, err=0} into the FIFO, then return to IDLE. Space is guaranteed because the space check happens at acceptance and only pops occur while busy.
- A/B/select hold their last values in IDLE; they change only on an accepted command.
- FIFO:
  - Circular buffer with log2(DEPTH)-bit read and write pointers that wrap modulo DEPTH, plus a count.
  - Push and pop in the same cycle leave the count unchanged.
  - A pop when empty is ignored.
  - res_data/res_op/res_err are the head entry and are valid only while res_valid is high.
- Reset mid-operation discards any in-flight command and all FIFO contents.

## Timing
- Reset values: A=0, B=0, select=0, cmd_ready=1 once rst_n deasserts (FIFO empty, IDLE), res_valid=0, res_data=0, res_op=0, res_err=0, busy=0, state=IDLE.
- A command accepted at edge N appears on A/B/select after edge N. The ALU result is captured at edge N+SETTLE_CYCLES+1. res_valid rises after that edge if the FIFO was empty.
- Throughput: one command per SETTLE_CYCLES+2 cycles. cmd_ready is low from acceptance until the return to IDLE, and while the FIFO is full.
- res_valid is high whenever count>0. Data holds stable until popped.

## Configuration
- ALU_SEQ_ERRCHK_EN defined:
  - An accepted cmd_op of 6 or 7 does not update A/B/select.
  - The command still takes SETTLE and CAPTURE, then pushes res_data=4'h0, res_op=cmd_op, res_err=1.
- ALU_SEQ_ERRCHK_EN undefined:
  - All opcodes are issued to the ALU unchanged, and ALU_Out is captured as-is.
  - res_err is tied 0 and no error logic is built.

## Test plan
- Reset: assert rst_n=0 mid-SETTLE with 2 entries queued -> immediately res_valid=0, busy=0, A=B=select=0; after release, cmd_ready=1.
- Single op, SETTLE_CYCLES=1, ALU model attached: cmd {op=5,a=3,b=3} at edge N -> select=5 after N; res_valid after edge N+2 with res_data=9, res_op=5, res_err=0.
- Back-to-back: AND 3,2; XOR 1,3; ADD 1,1 with res_ready=1 -> results 2, 2, 2 in order, with opcodes 0, 2, 3; one accept per 3 cycles.
- Full FIFO, DEPTH=4, res_ready=0: 4 commands -> cmd_ready stays low after the 4th capture. One pop -> cmd_ready=1 next cycle. Pointers wrap correctly over 10 further commands.
- Simultaneous push/pop: capture in the same cycle as a pop with count=2 -> count stays 2, order preserved.
- ALU_SEQ_ERRCHK_EN defined: cmd op=7 after a MUL 2,3 -> select stays 5; entry res_data=0, res_op=7, res_err=1. Undefined: select=7 and res_err=0.
